s_term_ram_io_pipe: RTL

S_TERM_RAM_IO_PIPE -- requirements
Module: s_term_ram_io_pipe

---
 rtl/s_term_pkg.sv | 27 ++
 rtl/s_term_delay_line.sv | 40 ++++
 rtl/s_term_ram_io_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/s_term_pkg.sv
// Shared definitions for the south-terminal RAM I/O pipe.
// Contents: per-group mode encoding, LFSR seed and tap positions, and the
// LFSR next-state helper.
package s_term_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_REG  = 2'b01,
    MODE_ZERO = 2'b10,
    MODE_LFSR = 2'b11
  } mode_e;

  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Bit indices of taps 16, 14, 13 and 11.
  localparam int unsigned LFSR_TAP_A = 15;
  localparam int unsigned LFSR_TAP_B = 13;
  localparam int unsigned LFSR_TAP_C = 12;
  localparam int unsigned LFSR_TAP_D = 10;

  // Fibonacci step: shift left, XOR of the taps enters at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/s_term_delay_line.sv
// Fixed-depth retiming delay line with synchronous active-high reset.
// Ports:
//   i_clk   - clock
//   i_rst   - synchronous active-high reset, clears every stage
//   i_data  - WIDTH-bit input
//   o_data  - i_data delayed by DEPTH cycles (combinational when DEPTH=0)
module s_term_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH > 3) begin : g_bad_depth
    $error("s_term_delay_line: DEPTH must be in 0..3");
    assign o_data = '0;
  end else if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = ^{i_clk, i_rst};
    assign o_data   = i_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_pipe [DEPTH];

    // Shift register; reset clears all stages so no stale pulse escapes.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= i_data;
        for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_data = r_pipe[DEPTH-1];
  end

endmodule

// File: rtl/s_term_ram_io_pipe.sv
// South-terminal RAM I/O pipe: loops S-side wire groups back to N-side with a
// configurable per-group mode, and retimes the frame buses.
// Ports:
//   UserCLK/UserRST        - clock, synchronous active-high reset
//   S1END/S2MID/S2END/S4END - wire-group inputs (groups 0..3)
//   N1BEG/N2BEG/N2BEGb/N4BEG - wire-group outputs (groups 0..3)
//   FrameData/FrameStrobe  - config frame buses; FrameStrobe[0] captures cfg
//   FrameData_O/FrameStrobe_O - frame buses delayed by STROBE_STAGES cycles
//   UserCLKo               - clock forwarded ungated
module s_term_ram_io_pipe
  import s_term_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NoConfigBits    = 8,
  parameter int unsigned W1              = 4,
  parameter int unsigned W2              = 8,
  parameter int unsigned W4              = 16,
  parameter int unsigned STROBE_STAGES   = 1
) (
  input  logic                       UserCLK,
  input  logic                       UserRST,
  input  logic [W1-1:0]              S1END,
  input  logic [W2-1:0]              S2MID,
  input  logic [W2-1:0]              S2END,
  input  logic [W4-1:0]              S4END,
  output logic [W1-1:0]              N1BEG,
  output logic [W2-1:0]              N2BEG,
  output logic [W2-1:0]              N2BEGb,
  output logic [W4-1:0]              N4BEG,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  output logic                       UserCLKo
);

  if (NoConfigBits != 8) begin : g_bad_cfg
    $error("s_term_ram_io_pipe: NoConfigBits must be 8");
  end

  localparam int unsigned MaxW12   = (W1 > W2) ? W1 : W2;
  localparam int unsigned MaxW     = (MaxW12 > W4) ? MaxW12 : W4;
  localparam int unsigned LfsrReps = (MaxW + LFSR_W - 1) / LFSR_W;

  logic [NoConfigBits-1:0]      r_cfg;
  logic [W1-1:0]                r_g0;
  logic [W2-1:0]                r_g1;
  logic [W2-1:0]                r_g2;
  logic [W4-1:0]                r_g3;
  logic [LFSR_W-1:0]            r_lfsr;

  mode_e                        w_mode0, w_mode1, w_mode2, w_mode3;
  logic                         w_any_lfsr;
  logic [LfsrReps*LFSR_W-1:0]   w_lfsr_rep;
  logic [MaxW-1:0]              w_lfsr_fill;

  assign w_mode0 = mode_e'(r_cfg[1:0]);
  assign w_mode1 = mode_e'(r_cfg[3:2]);
  assign w_mode2 = mode_e'(r_cfg[5:4]);
  assign w_mode3 = mode_e'(r_cfg[7:6]);

  assign w_any_lfsr = (w_mode0 == MODE_LFSR) || (w_mode1 == MODE_LFSR) ||
                      (w_mode2 == MODE_LFSR) || (w_mode3 == MODE_LFSR);

  // Wide groups see the 16-bit pattern repeated.
  assign w_lfsr_rep  = {LfsrReps{r_lfsr}};
  assign w_lfsr_fill = MaxW'(w_lfsr_rep);

  // Config capture, group registers (load every cycle so a switch to
  // registered mode shows the prior-cycle input at once), LFSR.
  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      r_cfg  <= '0;
      r_g0   <= '0;
      r_g1   <= '0;
      r_g2   <= '0;
      r_g3   <= '0;
      r_lfsr <= LFSR_SEED;
    end else begin
      if (FrameStrobe[0]) r_cfg <= FrameData[NoConfigBits-1:0];
      r_g0 <= S1END;
      r_g1 <= S2MID;
      r_g2 <= S2END;
      r_g3 <= S4END;
      if (w_any_lfsr) r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // Per-group output selection at the widest group width.
  function automatic logic [MaxW-1:0] f_group(input mode_e m,
                                              input logic [MaxW-1:0] pass,
                                              input logic [MaxW-1:0] regd,
                                              input logic [MaxW-1:0] lfsr);
    logic [MaxW-1:0] res;
    case (m)
      MODE_PASS: res = pass;
      MODE_REG:  res = regd;
      MODE_ZERO: res = '0;
      default:   res = lfsr;
    endcase
    return res;
  endfunction

  assign N1BEG  = W1'(f_group(w_mode0, MaxW'(S1END), MaxW'(r_g0), w_lfsr_fill));
  assign N2BEG  = W2'(f_group(w_mode1, MaxW'(S2MID), MaxW'(r_g1), w_lfsr_fill));
  assign N2BEGb = W2'(f_group(w_mode2, MaxW'(S2END), MaxW'(r_g2), w_lfsr_fill));
  assign N4BEG  = W4'(f_group(w_mode3, MaxW'(S4END), MaxW'(r_g3), w_lfsr_fill));

  assign UserCLKo = UserCLK;

  s_term_delay_line #(
    .WIDTH (MaxFramesPerCol),
    .DEPTH (STROBE_STAGES)
  ) u_strobe_dly (
    .i_clk  (UserCLK),
    .i_rst  (UserRST),
    .i_data (FrameStrobe),
    .o_data (FrameStrobe_O)
  );

  s_term_delay_line #(
    .WIDTH (FrameBitsPerRow),
    .DEPTH (STROBE_STAGES)
  ) u_data_dly (
    .i_clk  (UserCLK),
    .i_rst  (UserRST),
    .i_data (FrameData),
    .o_data (FrameData_O)
  );

endmodule
